// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Shares right-of-way between the highway, the side-lane sensor and the
// pedestrian button. The phase timings are min/max green, yellow, all-red
// clearance and walk. When the lane and the pedestrian are both waiting,
// they are served in round-robin order.
// Optional feature macro: EMERG_PREEMPT_EN. It adds the emerg_req port and
// the preempt behaviour.
module traffic_phase_scheduler #(
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 20,
    parameter int MAX_GREEN = 60,
    parameter int YELLOW_T  = 5,
    parameter int ALL_RED_T = 2,
    parameter int WALK_T    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor,
    input  logic       ped_req,
`ifdef EMERG_PREEMPT_EN
    input  logic       emerg_req,
`endif
    output logic [1:0] highway_signal,
    output logic [1:0] lane_signal,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        HW_GREEN    = 3'd0,
        HW_YELLOW   = 3'd1,
        CLEAR       = 3'd2,
        LANE_GREEN  = 3'd3,
        LANE_YELLOW = 3'd4,
        PED_WALK    = 3'd5
    } state_t;

    localparam logic [1:0] SIG_RED    = 2'b00;
    localparam logic [1:0] SIG_YELLOW = 2'b01;
    localparam logic [1:0] SIG_GREEN  = 2'b10;

    // Last-cycle timer values. A state of length T exits when the timer reads T-1.
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    state_t           clear_dst_reg, clear_dst_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             lane_pend_reg, lane_pend_next;
    logic             ped_pend_reg, ped_pend_next;
    logic             rr_reg, rr_next;
    logic             ped_ack_reg, ped_ack_next;
    logic             emerg;
    logic             state_change;
    logic             enter_lane;
    logic             enter_ped;

`ifdef EMERG_PREEMPT_EN
    assign emerg = emerg_req;
`else
    assign emerg = 1'b0;
`endif

    // State, timer, pending flags, round-robin pointer and ack pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= HW_GREEN;
            clear_dst_reg <= HW_GREEN;
            timer_reg     <= '0;
            lane_pend_reg <= 1'b0;
            ped_pend_reg  <= 1'b0;
            rr_reg        <= 1'b0;
            ped_ack_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clear_dst_reg <= clear_dst_next;
            timer_reg     <= timer_next;
            lane_pend_reg <= lane_pend_next;
            ped_pend_reg  <= ped_pend_next;
            rr_reg        <= rr_next;
            ped_ack_reg   <= ped_ack_next;
        end
    end

    // Next-state logic and the clearance destination chosen on the way into CLEAR
    always_comb begin
        state_next     = state_reg;
        clear_dst_next = clear_dst_reg;
        case (state_reg)
            HW_GREEN: begin
                // The highway has no maximum green, so it holds until a side request arrives.
                if (!emerg && (timer_reg >= MIN_LAST) && (lane_pend_reg || ped_pend_reg))
                    state_next = HW_YELLOW;
            end
            HW_YELLOW: begin
                if (timer_reg == YEL_LAST) begin
                    state_next = CLEAR;
                    if (lane_pend_reg && ped_pend_reg)
                        clear_dst_next = rr_reg ? PED_WALK : LANE_GREEN;
                    else if (lane_pend_reg)
                        clear_dst_next = LANE_GREEN;
                    else if (ped_pend_reg)
                        clear_dst_next = PED_WALK;
                    else
                        clear_dst_next = HW_GREEN;
                end
            end
            CLEAR: begin
                // A preempt redirects a pending side phase back to the highway.
                if (timer_reg == AR_LAST)
                    state_next = emerg ? HW_GREEN : clear_dst_reg;
            end
            LANE_GREEN: begin
                if (emerg || ((timer_reg >= MIN_LAST) && (!sensor || (timer_reg == MAX_LAST))))
                    state_next = LANE_YELLOW;
            end
            LANE_YELLOW: begin
                if (timer_reg == YEL_LAST) begin
                    state_next     = CLEAR;
                    clear_dst_next = HW_GREEN;
                end
            end
            PED_WALK: begin
                if (emerg || (timer_reg == WALK_LAST)) begin
                    state_next     = CLEAR;
                    clear_dst_next = HW_GREEN;
                end
            end
            default: begin
                state_next     = HW_GREEN;
                clear_dst_next = HW_GREEN;
            end
        endcase
    end

    // Timer, request latching and grant bookkeeping
    always_comb begin
        state_change = (state_next != state_reg);
        enter_lane   = state_change && (state_next == LANE_GREEN);
        enter_ped    = state_change && (state_next == PED_WALK);

        if (state_change)
            timer_next = '0;
        else if (timer_reg == TIMER_MAX)
            timer_next = timer_reg;
        else
            timer_next = timer_reg + 1'b1;

        // When a grant is entered, the pending flag clears, even if the request is still present in that cycle.
        lane_pend_next = lane_pend_reg;
        if (enter_lane)
            lane_pend_next = 1'b0;
        else if (sensor && (state_reg != LANE_GREEN))
            lane_pend_next = 1'b1;

        ped_pend_next = ped_pend_reg;
        if (enter_ped)
            ped_pend_next = 1'b0;
        else if (ped_req && (state_reg != PED_WALK))
            ped_pend_next = 1'b1;

        rr_next = rr_reg;
        if (enter_lane)
            rr_next = 1'b1;
        else if (enter_ped)
            rr_next = 1'b0;

        ped_ack_next = enter_ped;
    end

    // Moore decode of the signal heads from the current state
    always_comb begin
        highway_signal = SIG_RED;
        lane_signal    = SIG_RED;
        walk           = 1'b0;
        case (state_reg)
            HW_GREEN:    highway_signal = SIG_GREEN;
            HW_YELLOW:   highway_signal = SIG_YELLOW;
            LANE_GREEN:  lane_signal    = SIG_GREEN;
            LANE_YELLOW: lane_signal    = SIG_YELLOW;
            PED_WALK:    walk           = 1'b1;
            default:     ;
        endcase
    end

    assign ped_ack = ped_ack_reg;
    assign phase   = state_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler. It runs with short timings and
// compares the DUT every cycle against a phase/duration reference model.
// It also makes directed checks on phase lengths and service order.
module tb_traffic_phase_scheduler;

    localparam int CNT_W = 8;
    localparam int MIN_G = 4;
    localparam int MAX_G = 8;
    localparam int YEL   = 2;
    localparam int ARED  = 1;
    localparam int WALKT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor;
    logic       ped_req;
    logic       emerg_req;
    logic [1:0] highway_signal;
    logic [1:0] lane_signal;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_phase_scheduler #(
        .CNT_W(CNT_W), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
        .YELLOW_T(YEL), .ALL_RED_T(ARED), .WALK_T(WALKT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sensor(sensor),
        .ped_req(ped_req),
`ifdef EMERG_PREEMPT_EN
        .emerg_req(emerg_req),
`endif
        .highway_signal(highway_signal),
        .lane_signal(lane_signal),
        .walk(walk),
        .ped_ack(ped_ack),
        .phase(phase)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Reference model. Phase ids: 0 hw green, 1 hw yellow, 2 clear,
    // 3 lane green, 4 lane yellow, 5 walk. m_age is the number of cycles
    // already spent in the phase.
    int m_phase, m_age, m_dst;
    bit m_lp, m_pp, m_rr, m_ack;

    function automatic int fixed_len(int ph);
        case (ph)
            1, 4:    return YEL;
            2:       return ARED;
            5:       return WALKT;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_dst = 0;
        m_lp = 0; m_pp = 0; m_rr = 0; m_ack = 0;
    endtask

    task automatic model_update(input bit s, input bit p, input bit e);
        int  np;
        int  nd;
        bit  last;
        bit  entering;
        np   = m_phase;
        nd   = m_dst;
        last = (fixed_len(m_phase) != 0) && (m_age + 1 >= fixed_len(m_phase));
        case (m_phase)
            0: if (!e && m_age + 1 >= MIN_G && (m_lp || m_pp)) np = 1;
            1: if (last) begin
                   np = 2;
                   // lane wins unless only ped waits, or both wait and it is ped's turn
                   nd = (m_lp && (!m_pp || !m_rr)) ? 3 : 5;
               end
            2: if (last) np = e ? 0 : m_dst;
            3: if (e || (m_age + 1 >= MIN_G && (!s || m_age + 1 >= MAX_G))) np = 4;
            4: if (last) begin np = 2; nd = 0; end
            5: if (last || e) begin np = 2; nd = 0; end
            default: np = 0;
        endcase
        entering = (np != m_phase);
        m_ack = entering && (np == 5);
        if (entering && np == 3) m_lp = 0; else if (s && m_phase != 3) m_lp = 1;
        if (entering && np == 5) m_pp = 0; else if (p && m_phase != 5) m_pp = 1;
        if (entering && np == 3) m_rr = 1;
        if (entering && np == 5) m_rr = 0;
        m_age   = entering ? 0 : m_age + 1;
        m_phase = np;
        m_dst   = nd;
    endtask

    function automatic logic [8:0] exp_vec();
        logic [1:0] hw;
        logic [1:0] ln;
        hw = (m_phase == 0) ? 2'b10 : (m_phase == 1) ? 2'b01 : 2'b00;
        ln = (m_phase == 3) ? 2'b10 : (m_phase == 4) ? 2'b01 : 2'b00;
        return {3'(m_phase), hw, ln, (m_phase == 5), m_ack};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {phase, highway_signal, lane_signal, walk, ped_ack};
    endfunction

    // One clock: apply inputs, let the DUT and the model see the same edge, then settle.
    task automatic step(input bit s, input bit p, input bit e);
        sensor = s; ped_req = p; emerg_req = e;
        @(posedge clk);
        model_update(s, p, e);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; sensor = 1'b0; ped_req = 1'b0; emerg_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sensor = 1'b1; ped_req = 1'b1; emerg_req = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== 9'b000_10_00_0_0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", dut_vec(), 9'b000_10_00_0_0);
        end
        // Requests that arrive while reset is held must not be latched.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0);
            n_checks++;
            if (dut_vec() !== exp_vec() || phase !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_lane_min();
        int lane_cyc = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step((i == 10 || i == 11), 0, 0);
            if (phase == 3'd3) lane_cyc++;
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lane_min cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (lane_cyc != MIN_G) begin
            n_fail++;
            $display("FAIL lane_min_len: got %0d cycles want %0d", lane_cyc, MIN_G);
        end
    endtask

    task automatic test_lane_max();
        int run = 0;
        int first_run = -1;
        int entries = 0;
        do_reset();
        for (int i = 0; i < 45; i++) begin
            step(1, 0, 0);
            if (phase == 3'd3) begin
                if (run == 0) entries++;
                run++;
            end else begin
                if (run > 0 && first_run < 0) first_run = run;
                run = 0;
            end
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lane_max cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (first_run != MAX_G) begin
            n_fail++;
            $display("FAIL lane_max_len: got %0d cycles want %0d", first_run, MAX_G);
        end
        n_checks++;
        if (entries < 2) begin
            n_fail++;
            $display("FAIL lane_reserve: got %0d lane phases want >=2", entries);
        end
    endtask

    task automatic test_round_robin();
        int t_lane = -1;
        int t_walk = -1;
        int walk_cyc = 0;
        int acks = 0;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            step((i == 0), (i == 0), 0);
            if (phase == 3'd3 && t_lane < 0) t_lane = i;
            if (phase == 3'd5 && t_walk < 0) t_walk = i;
            if (walk) walk_cyc++;
            if (ped_ack) acks++;
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL round_robin cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (!(t_lane >= 0 && t_walk > t_lane)) begin
            n_fail++;
            $display("FAIL rr_order: got lane@%0d walk@%0d want lane before walk", t_lane, t_walk);
        end
        n_checks++;
        if (walk_cyc != WALKT || acks != 1) begin
            n_fail++;
            $display("FAIL walk_len: got %0d walk %0d ack want %0d walk 1 ack", walk_cyc, acks, WALKT);
        end
    endtask

    task automatic test_reset_mid_phase();
        int guard = 0;
        do_reset();
        step(1, 0, 0);
        while (m_phase != 3 && guard < 40) begin
            step(1, 0, 0);
            guard++;
        end
        n_checks++;
        if (phase !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_reset_setup: got phase %0d want 3", phase);
        end
        step(1, 1, 0);
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== 9'b000_10_00_0_0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want %b", dut_vec(), 9'b000_10_00_0_0);
        end
        sensor = 1'b0; ped_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        // Both pendings were wiped, so the highway must simply hold.
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            n_checks++;
            if (dut_vec() !== exp_vec() || phase !== 3'd0) begin
                n_fail++;
                $display("FAIL mid_reset_hold cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

`ifdef EMERG_PREEMPT_EN
    task automatic test_emergency();
        int guard = 0;
        bit walk_during = 0;
        bit walk_after = 0;
        do_reset();
        step(1, 1, 0);
        while (m_phase != 3 && guard < 40) begin
            step(0, 0, 0);
            guard++;
        end
        step(0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1);
            if (phase == 3'd5) walk_during = 1;
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL emerg cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0);
            if (phase == 3'd5) walk_after = 1;
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL emerg_release cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (walk_during || !walk_after) begin
            n_fail++;
            $display("FAIL emerg_ped: got during=%0d after=%0d want during=0 after=1", walk_during, walk_after);
        end
    endtask
`endif

    task automatic test_random();
        bit s, p, e;
        int pct_s, pct_p;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            pct_s = (i < 500) ? 10 : (i < 1000) ? 60 : 30;
            pct_p = (i < 500) ? 5 : (i < 1000) ? 20 : 50;
            s = ($urandom_range(99) < pct_s);
            p = ($urandom_range(99) < pct_p);
`ifdef EMERG_PREEMPT_EN
            e = ($urandom_range(99) < 4);
`else
            e = 1'b0;
`endif
            step(s, p, e);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b (s=%0d p=%0d e=%0d)", i, dut_vec(), exp_vec(), s, p, e);
            end
        end
    endtask

    initial begin
        rst = 1'b0; sensor = 1'b0; ped_req = 1'b0; emerg_req = 1'b0;
        test_reset();
        test_lane_min();
        test_lane_max();
        test_round_robin();
        test_reset_mid_phase();
`ifdef EMERG_PREEMPT_EN
        test_emergency();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
